fp_mul_pipe_param: RTL

// - Parametrised IEEE-style floating-point multiplier with a 3-stage pipeline; BF16 by default, FP32 via parameters.
// - Successor to the fixed BF16 multiplier. Adds:
//   - valid/ready backpressure at every stage;
//   - round-to-nearest-even;
//   - canonical-NaN handling and exception flags;
//   - a tag carried alongside each operation.
// - Sits between the operand scheduler and the node accumulator in the probabilistic-circuit datapath.

---
 rtl/fp_mul_pkg.sv | 28 ++
 rtl/fp_mul_round.sv | 51 +++++
 rtl/fp_mul_pipe_param.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants, operand classes and field-constant helpers for the pipelined FP multiplier.
package fp_mul_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 7;
  localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Magnitudes are returned wide; callers keep the low 1+EXP_W+MAN_W bits.
  function automatic logic [63:0] inf_mag(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] qnan_val(input int exp_w, input int man_w);
    return inf_mag(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalise the raw mantissa product, round to nearest even, and saturate to inf or flush to zero.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                           sgn_i,
  input  logic [2*MAN_W+1:0]             prod_i,
  input  logic signed [EXP_W+1:0]        exp_i,
  output logic [EXP_W+MAN_W:0]           z_o,
  output logic                           ovf_o,
  output logic                           udf_o,
  output logic                           inx_o
);
  localparam int PW  = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] ZRO  = '0;
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic [63:0] INF64 = inf_mag(EXP_W, MAN_W);
  localparam logic [EXP_W+MAN_W-1:0] INF_MAG = INF64[EXP_W+MAN_W-1:0];

  function automatic logic rne_up(input logic grd, input logic stk, input logic lsb);
    return grd & (stk | lsb);
  endfunction

  logic [PW-2:0]           norm;
  logic signed [EW2-1:0]   exp_n, exp_r;
  logic [MAN_W-1:0]        man;
  logic [MAN_W:0]          man_r;
  logic                    grd, stk;

  always_comb begin
    // Product lies in [1,4); align so the hidden bit is dropped and the fraction starts at PW-2.
    norm  = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
    exp_n = prod_i[PW-1] ? exp_i + ONE : exp_i;
    man   = norm[PW-2 -: MAN_W];
    grd   = norm[PW-2-MAN_W];
    stk   = |norm[PW-3-MAN_W:0];
    man_r = {1'b0, man} + {{MAN_W{1'b0}}, rne_up(grd, stk, man[0])};
    exp_r = exp_n + (man_r[MAN_W] ? ONE : ZRO);
    ovf_o = (exp_r >= EMAX);
    udf_o = !ovf_o && (exp_r <= ZRO);
    inx_o = grd | stk | ovf_o | udf_o;
    z_o   = {sgn_i, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
    if (ovf_o)      z_o = {sgn_i, INF_MAG};
    else if (udf_o) z_o = {sgn_i, {(EXP_W+MAN_W){1'b0}}};
  end

endmodule

// File: rtl/fp_mul_pipe_param.sv
// Three-stage FP multiplier (classify, multiply, round) with elastic valid/ready stages and a pass-through tag.
module fp_mul_pipe_param
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(bias_of(EXP_W));
  localparam logic [63:0] INF64 = inf_mag(EXP_W, MAN_W);
  localparam logic [63:0] NAN64 = qnan_val(EXP_W, MAN_W);
  localparam logic [W-2:0] INF_MAG = INF64[W-2:0];
  localparam logic [W-1:0] QNAN    = NAN64[W-1:0];

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (&e)      return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

  logic vld_p0_q, vld_p1_q, vld_p2_q;
  logic en_p0, en_p1, en_p2;

  logic                 sgn_p0_q;
  fp_class_e            cls_a_p0_q, cls_b_p0_q;
  logic [EXP_W-1:0]     exp_a_p0_q, exp_b_p0_q;
  logic [MAN_W:0]       man_a_p0_q, man_b_p0_q;
  logic [TAG_W-1:0]     tag_p0_q;

  logic                 sgn_p1_q, spc_p1_q, inv_p1_q;
  logic                 spc_p1_d, inv_p1_d;
  logic [W-1:0]         spc_z_p1_q, spc_z_p1_d;
  logic [PW-1:0]        prod_p1_q, prod_p1_d;
  logic signed [EW2-1:0] exp_p1_q, exp_p1_d;
  logic [TAG_W-1:0]     tag_p1_q;

  logic [W-1:0]         z_p2_q, z_p2_d;
  logic [3:0]           flg_p2_q, flg_p2_d;
  logic [TAG_W-1:0]     tag_p2_q;

  logic [W-1:0]         rnd_z;
  logic                 rnd_ovf, rnd_udf, rnd_inx;

  // A stage loads whenever it is empty or its contents move on, so bubbles collapse.
  assign en_p2    = !vld_p2_q | out_ready;
  assign en_p1    = !vld_p1_q | en_p2;
  assign en_p0    = !vld_p0_q | en_p1;
  assign in_ready = en_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (en_p0) vld_p0_q <= in_valid;
      if (en_p1) vld_p1_q <= vld_p0_q;
      if (en_p2) vld_p2_q <= vld_p1_q;
    end
  end

  // Stage p0: unpack and classify; subnormals classify as zero.
  always_ff @(posedge clk) begin
    if (en_p0 && in_valid) begin
      sgn_p0_q   <= in_a[W-1] ^ in_b[W-1];
      cls_a_p0_q <= classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
      cls_b_p0_q <= classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
      exp_a_p0_q <= in_a[W-2:MAN_W];
      exp_b_p0_q <= in_b[W-2:MAN_W];
      man_a_p0_q <= {1'b1, in_a[MAN_W-1:0]};
      man_b_p0_q <= {1'b1, in_b[MAN_W-1:0]};
      tag_p0_q   <= in_tag;
    end
  end

  always_comb begin
    prod_p1_d  = PW'(man_a_p0_q) * PW'(man_b_p0_q);
    exp_p1_d   = $signed({2'b00, exp_a_p0_q}) + $signed({2'b00, exp_b_p0_q}) - BIAS_S;
    spc_p1_d   = 1'b1;
    inv_p1_d   = 1'b0;
    spc_z_p1_d = {sgn_p0_q, INF_MAG};
    if (cls_a_p0_q == NAN || cls_b_p0_q == NAN ||
        (cls_a_p0_q == INF && cls_b_p0_q == ZERO) || (cls_a_p0_q == ZERO && cls_b_p0_q == INF)) begin
      spc_z_p1_d = QNAN;
      inv_p1_d   = 1'b1;
    end else if (cls_a_p0_q == INF || cls_b_p0_q == INF) begin
      spc_z_p1_d = {sgn_p0_q, INF_MAG};
    end else if (cls_a_p0_q == ZERO || cls_b_p0_q == ZERO) begin
      spc_z_p1_d = {sgn_p0_q, {(W-1){1'b0}}};
    end else begin
      spc_p1_d   = 1'b0;
    end
  end

  // Stage p1: mantissa product, biased exponent sum, special-case result.
  always_ff @(posedge clk) begin
    if (en_p1 && vld_p0_q) begin
      sgn_p1_q   <= sgn_p0_q;
      spc_p1_q   <= spc_p1_d;
      inv_p1_q   <= inv_p1_d;
      spc_z_p1_q <= spc_z_p1_d;
      prod_p1_q  <= prod_p1_d;
      exp_p1_q   <= exp_p1_d;
      tag_p1_q   <= tag_p0_q;
    end
  end

  fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sgn_i  (sgn_p1_q),
    .prod_i (prod_p1_q),
    .exp_i  (exp_p1_q),
    .z_o    (rnd_z),
    .ovf_o  (rnd_ovf),
    .udf_o  (rnd_udf),
    .inx_o  (rnd_inx)
  );

  always_comb begin
    z_p2_d            = rnd_z;
    flg_p2_d          = '0;
    flg_p2_d[FLG_OVF] = rnd_ovf;
    flg_p2_d[FLG_UDF] = rnd_udf;
    flg_p2_d[FLG_INX] = rnd_inx;
    if (spc_p1_q) begin
      z_p2_d            = spc_z_p1_q;
      flg_p2_d          = '0;
      flg_p2_d[FLG_INV] = inv_p1_q;
    end
  end

  // Stage p2: rounded result held as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_p2_q   <= '0;
      tag_p2_q <= '0;
      flg_p2_q <= '0;
    end else if (en_p2 && vld_p1_q) begin
      z_p2_q   <= z_p2_d;
      tag_p2_q <= tag_p1_q;
      flg_p2_q <= flg_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_z     = z_p2_q;
  assign out_tag   = tag_p2_q;
  assign out_flags = flg_p2_q;

endmodule
